writeback_arbiter: RTL and testbench

- Producer side of the register file write port. Collects completed results from ALU, memory and FPU.
- Buffers them in small per-source FIFOs and issues exactly one registered write per cycle.
- Drives rd_wb / write_data_register_wb / regwrite_wb, with back-pressure to each producer.

---
 rtl/writeback_arbiter.sv | 160 ++++++++++++++++
 tb/tb_writeback_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - three-source writeback arbiter feeding the register file write port
// Per-source FIFOs with starvation-aware fixed priority (mem > fpu > alu) and a registered write stage.
module writeback_arbiter #(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        alu_valid,
   input  logic [4:0]  alu_rd,
   input  logic [1:0]  alu_kind,
   input  logic [31:0] alu_data,
   output logic        alu_ready,
   input  logic        mem_valid,
   input  logic [4:0]  mem_rd,
   input  logic [1:0]  mem_kind,
   input  logic [31:0] mem_data,
   output logic        mem_ready,
   input  logic        fpu_valid,
   input  logic [4:0]  fpu_rd,
   input  logic [1:0]  fpu_kind,
   input  logic [31:0] fpu_data,
   output logic        fpu_ready,
   output logic [4:0]  rd_wb,
   output logic [31:0] write_data_register_wb,
   output logic [1:0]  regwrite_wb,
   output logic        busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam int EW = 39;
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   // Source index 0 = mem, 1 = fpu, 2 = alu, which is also the default priority order.
   logic [2:0]    in_valid;
   logic [1:0]    in_kind [3];
   logic [4:0]    in_rd   [3];
   logic [31:0]   in_data [3];

   logic [AW:0]   wr_q [3];
   logic [AW:0]   rd_q [3];
   logic [EW-1:0] buf_q [3][DEPTH];
   logic [CW-1:0] cnt_q [3];
   logic [CW-1:0] cnt_d [3];

   logic [2:0]    full;
   logic [2:0]    empty;
   logic [2:0]    push;
   logic [2:0]    starved;
   logic [2:0]    grant;
   logic [EW-1:0] head;
   logic          suppress;

   logic [1:0]    wb_kind_q, wb_kind_d;
   logic [4:0]    wb_rd_q, wb_rd_d;
   logic [31:0]   wb_data_q, wb_data_d;

   assign in_valid   = {alu_valid, fpu_valid, mem_valid};
   assign in_kind[0] = mem_kind;
   assign in_kind[1] = fpu_kind;
   assign in_kind[2] = alu_kind;
   assign in_rd[0]   = mem_rd;
   assign in_rd[1]   = fpu_rd;
   assign in_rd[2]   = alu_rd;
   assign in_data[0] = mem_data;
   assign in_data[1] = fpu_data;
   assign in_data[2] = alu_data;

   always_comb begin
      full    = '0;
      empty   = '0;
      push    = '0;
      starved = '0;
      for (int i = 0; i < 3; i++) begin
         full[i]    = (wr_q[i][AW] != rd_q[i][AW]) && (wr_q[i][AW-1:0] == rd_q[i][AW-1:0]);
         empty[i]   = (wr_q[i] == rd_q[i]);
         // Non-writing kinds are handshaken but never stored.
         push[i]    = in_valid[i] && !full[i] && (in_kind[i] == 2'b01 || in_kind[i] == 2'b10);
         starved[i] = !empty[i] && (cnt_q[i] == LIMIT);
      end
   end

   assign mem_ready = !full[0];
   assign fpu_ready = !full[1];
   assign alu_ready = !full[2];

   always_comb begin
      grant = '0;
      if      (starved[0]) grant = 3'b001;
      else if (starved[1]) grant = 3'b010;
      else if (starved[2]) grant = 3'b100;
      else if (!empty[0])  grant = 3'b001;
      else if (!empty[1])  grant = 3'b010;
      else if (!empty[2])  grant = 3'b100;
   end

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         cnt_d[i] = cnt_q[i];
         if (empty[i] || grant[i])
            cnt_d[i] = '0;
         else if (cnt_q[i] != LIMIT)
            cnt_d[i] = cnt_q[i] + CW'(1);
      end
   end

   always_comb begin
      head = '0;
      for (int i = 0; i < 3; i++)
         if (grant[i]) head = buf_q[i][rd_q[i][AW-1:0]];
   end

   assign suppress = (head[38:37] == 2'b01 && head[36:32] == 5'd0) ||
                     (head[38:37] == 2'b10 && head[36:32] == 5'd30);

   always_comb begin
      wb_kind_d = 2'b00;
      wb_rd_d   = 5'd0;
      wb_data_d = 32'd0;
      if (|grant && !suppress) begin
         wb_kind_d = head[38:37];
         wb_rd_d   = head[36:32];
         wb_data_d = head[31:0];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < 3; i++) begin
            wr_q[i]  <= '0;
            rd_q[i]  <= '0;
            cnt_q[i] <= '0;
         end
         wb_kind_q <= 2'b00;
         wb_rd_q   <= 5'd0;
         wb_data_q <= 32'd0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (push[i])  wr_q[i] <= wr_q[i] + (AW+1)'(1);
            if (grant[i]) rd_q[i] <= rd_q[i] + (AW+1)'(1);
            cnt_q[i] <= cnt_d[i];
         end
         wb_kind_q <= wb_kind_d;
         wb_rd_q   <= wb_rd_d;
         wb_data_q <= wb_data_d;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 3; i++)
         if (push[i]) buf_q[i][wr_q[i][AW-1:0]] <= {in_kind[i], in_rd[i], in_data[i]};
   end

   assign regwrite_wb            = wb_kind_q;
   assign rd_wb                  = wb_rd_q;
   assign write_data_register_wb = wb_data_q;
   assign busy                   = !(&empty) || (wb_kind_q != 2'b00);

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - scoreboard bench for writeback_arbiter
// Accepted writes are queued per source; a negedge monitor matches every register write against queue heads.
module tb_writeback_arbiter;

   logic        clk = 1'b0;
   logic        rstn;
   logic        alu_valid, mem_valid, fpu_valid;
   logic [4:0]  alu_rd, mem_rd, fpu_rd;
   logic [1:0]  alu_kind, mem_kind, fpu_kind;
   logic [31:0] alu_data, mem_data, fpu_data;
   logic        alu_ready, mem_ready, fpu_ready;
   logic [4:0]  rd_wb;
   logic [31:0] write_data_register_wb;
   logic [1:0]  regwrite_wb;
   logic        busy;

   writeback_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rstn(rstn),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_kind(alu_kind), .alu_data(alu_data), .alu_ready(alu_ready),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_kind(mem_kind), .mem_data(mem_data), .mem_ready(mem_ready),
      .fpu_valid(fpu_valid), .fpu_rd(fpu_rd), .fpu_kind(fpu_kind), .fpu_data(fpu_data), .fpu_ready(fpu_ready),
      .rd_wb(rd_wb), .write_data_register_wb(write_data_register_wb),
      .regwrite_wb(regwrite_wb), .busy(busy)
   );

   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;
   int n_writes   = 0;
   int alu_acc_edge = -1;
   int alu9_wr      = -1;
   logic [38:0] q_mem[$];
   logic [38:0] q_fpu[$];
   logic [38:0] q_alu[$];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic bit keep(input logic [1:0] k, input logic [4:0] rd);
      return (k == 2'b01 && rd != 5'd0) || (k == 2'b10 && rd != 5'd30);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Stimulus side of the scoreboard: every handshaken writing result becomes an expectation.
   always @(posedge clk) begin
      if (rstn) begin
         if (mem_valid && mem_ready && keep(mem_kind, mem_rd)) q_mem.push_back({mem_kind, mem_rd, mem_data});
         if (fpu_valid && fpu_ready && keep(fpu_kind, fpu_rd)) q_fpu.push_back({fpu_kind, fpu_rd, fpu_data});
         if (alu_valid && alu_ready && keep(alu_kind, alu_rd)) q_alu.push_back({alu_kind, alu_rd, alu_data});
         if (alu_valid && alu_ready && alu_kind == 2'b01 && alu_rd == 5'd9) alu_acc_edge = cyc + 1;
      end
   end

   always @(negedge clk) begin
      logic [38:0] w;
      if (rstn) begin
         w = {regwrite_wb, rd_wb, write_data_register_wb};
         compared++;
         if (regwrite_wb != 2'b00) begin
            n_writes++;
            if (q_mem.size() > 0 && q_mem[0] == w) void'(q_mem.pop_front());
            else if (q_fpu.size() > 0 && q_fpu[0] == w) void'(q_fpu.pop_front());
            else if (q_alu.size() > 0 && q_alu[0] == w) begin
               void'(q_alu.pop_front());
               if (rd_wb == 5'd9) alu9_wr = cyc;
            end else begin
               mismatched++;
               $display("FAIL sb_write: actual kind=%b rd=%0d data=%h required a pending source head",
                        regwrite_wb, rd_wb, write_data_register_wb);
            end
         end else if (rd_wb != 5'd0 || write_data_register_wb != 32'd0) begin
            mismatched++;
            $display("FAIL idle_zero: actual rd=%0d data=%h required 0/0", rd_wb, write_data_register_wb);
         end
      end
   end

   task automatic idle_inputs();
      alu_valid = 0; alu_kind = 0; alu_rd = 0; alu_data = 0;
      mem_valid = 0; mem_kind = 0; mem_rd = 0; mem_data = 0;
      fpu_valid = 0; fpu_kind = 0; fpu_rd = 0; fpu_data = 0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((busy || q_mem.size() + q_fpu.size() + q_alu.size() != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_drained"}, 64'(n < 100), 64'd1);
      chk({name, "_sb_empty"}, 64'(q_mem.size() + q_fpu.size() + q_alu.size()), 64'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: actual=expired required=finished");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
      $fatal(1);
   end

   initial begin
      int base, acc, k;
      bit a, did;
      idle_inputs();
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_out", {regwrite_wb, rd_wb, write_data_register_wb}, 39'd0);
      chk("reset_busy", busy, 0);
      @(posedge clk); #1 rstn = 1'b1;
      @(negedge clk);
      chk("reset_ready", {alu_ready, mem_ready, fpu_ready}, 3'b111);

      // Single ALU push, two-cycle latency, one-cycle write.
      @(posedge clk); #1;
      alu_valid = 1; alu_kind = 2'b01; alu_rd = 5'd5; alu_data = 32'h12345678;
      @(posedge clk); #1 idle_inputs();
      @(negedge clk);
      chk("t1_not_early", regwrite_wb, 2'b00);
      chk("t1_busy_rise", busy, 1);
      @(negedge clk);
      chk("t1_write", {regwrite_wb, rd_wb, write_data_register_wb}, {2'b01, 5'd5, 32'h12345678});
      @(negedge clk);
      chk("t1_idle_after", regwrite_wb, 2'b00);
      chk("t1_busy_fall", busy, 0);
      drain("t1");

      // Same-cycle pushes from all three sources leave in default priority order.
      @(posedge clk); #1;
      mem_valid = 1; mem_kind = 2'b10; mem_rd = 5'd3; mem_data = 32'h3F800000;
      fpu_valid = 1; fpu_kind = 2'b01; fpu_rd = 5'd7; fpu_data = 32'h0000000A;
      alu_valid = 1; alu_kind = 2'b01; alu_rd = 5'd8; alu_data = 32'h0000000B;
      @(posedge clk); #1 idle_inputs();
      @(negedge clk);
      @(negedge clk);
      chk("t2_first_mem", {regwrite_wb, rd_wb, write_data_register_wb}, {2'b10, 5'd3, 32'h3F800000});
      @(negedge clk);
      chk("t2_second_fpu", {regwrite_wb, rd_wb, write_data_register_wb}, {2'b01, 5'd7, 32'h0000000A});
      @(negedge clk);
      chk("t2_third_alu", {regwrite_wb, rd_wb, write_data_register_wb}, {2'b01, 5'd8, 32'h0000000B});
      drain("t2");

      // Starvation: alu entry enqueued one cycle after mem/fpu start streaming.
      alu9_wr = -1; alu_acc_edge = -1;
      @(posedge clk); #1;
      for (int i = 0; i < 12; i++) begin
         mem_valid = 1; mem_kind = 2'b01; mem_rd = 5'(i + 1);  mem_data = 32'h10000000 + i;
         fpu_valid = 1; fpu_kind = 2'b01; fpu_rd = 5'(i + 13); fpu_data = 32'h20000000 + i;
         if (i == 1) begin
            alu_valid = 1; alu_kind = 2'b01; alu_rd = 5'd9; alu_data = 32'hC0DE0009;
         end else begin
            alu_valid = 0;
         end
         @(posedge clk); #1;
      end
      idle_inputs();
      drain("t3");
      chk("t3_alu_accepted", 64'(alu_acc_edge > 0 && alu9_wr > 0), 64'd1);
      chk("t3_alu_latency_le5", 64'((alu9_wr - alu_acc_edge) <= 5), 64'd1);

      // Back-pressure on alu while mem and fpu saturate the port.
      acc = 0; k = 0; did = 0;
      @(posedge clk); #1;
      while (acc < 5 && k < 200) begin
         mem_valid = 1; mem_kind = 2'b01; mem_rd = 5'((k % 20) + 1); mem_data = 32'h30000000 + k;
         fpu_valid = 1; fpu_kind = 2'b10; fpu_rd = 5'((k % 20) + 1); fpu_data = 32'h40000000 + k;
         alu_valid = 1; alu_kind = 2'b01; alu_rd = 5'(10 + acc);    alu_data = 32'hA1000000 + acc;
         @(negedge clk);
         if (acc == 2 && !did) begin
            chk("t4_alu_backpressure", alu_ready, 0);
            did = 1;
         end
         a = alu_ready;
         @(posedge clk); #1;
         if (a) acc++;
         k++;
      end
      idle_inputs();
      chk("t4_all_accepted", acc, 5);
      drain("t4");

      // Suppressed zero registers and non-writing kind.
      base = n_writes;
      @(posedge clk); #1;
      alu_valid = 1; alu_kind = 2'b01; alu_rd = 5'd0;  alu_data = 32'h1;
      mem_valid = 1; mem_kind = 2'b10; mem_rd = 5'd30; mem_data = 32'h2;
      fpu_valid = 1; fpu_kind = 2'b11; fpu_rd = 5'd4;  fpu_data = 32'h3;
      @(posedge clk); #1 idle_inputs();
      @(negedge clk);
      chk("t5_busy_while_buffered", busy, 1);
      drain("t5");
      chk("t5_no_writes", n_writes - base, 0);

      // Opposite-file index pairs are real writes.
      base = n_writes;
      @(posedge clk); #1;
      alu_valid = 1; alu_kind = 2'b10; alu_rd = 5'd0;  alu_data = 32'h55;
      mem_valid = 1; mem_kind = 2'b01; mem_rd = 5'd30; mem_data = 32'h66;
      @(posedge clk); #1 idle_inputs();
      drain("t5b");
      chk("t5b_two_writes", n_writes - base, 2);

      // Mid-stream asynchronous reset discards everything buffered.
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         mem_valid = 1; mem_kind = 2'b01; mem_rd = 5'(i + 1); mem_data = 32'h50000000 + i;
         fpu_valid = 1; fpu_kind = 2'b10; fpu_rd = 5'(i + 4); fpu_data = 32'h60000000 + i;
         alu_valid = 1; alu_kind = 2'b01; alu_rd = 5'(i + 7); alu_data = 32'h70000000 + i;
         @(posedge clk); #1;
      end
      idle_inputs();
      @(negedge clk);
      chk("t6_write_before_reset", 64'(regwrite_wb != 2'b00), 64'd1);
      #1 rstn = 1'b0;
      #1;
      chk("t6_async_out", {regwrite_wb, rd_wb, write_data_register_wb}, 39'd0);
      chk("t6_async_busy", busy, 0);
      q_mem.delete(); q_fpu.delete(); q_alu.delete();
      base = n_writes;
      @(posedge clk); #1 rstn = 1'b1;
      repeat (10) @(negedge clk);
      chk("t6_no_stale", n_writes - base, 0);
      chk("t6_busy_idle", busy, 0);
      chk("t6_ready", {alu_ready, mem_ready, fpu_ready}, 3'b111);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
